// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register: carries the decode bundle into execute with
// stall hold, bubble insertion, flush, delay-slot feedback and a bubble counter.
module id_ex_pipe #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                stall_id,
    input  logic                stall_ex,
    input  logic                cnt_clr,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [DATA_W-1:0]   id_reg1,
    input  logic [DATA_W-1:0]   id_reg2,
    input  logic [REG_AW-1:0]   id_wd,
    input  logic                id_wreg,
    input  logic [DATA_W-1:0]   id_inst,
    input  logic [DATA_W-1:0]   id_link_addr,
    input  logic                id_is_in_delayslot,
    input  logic                next_inst_in_delayslot_i,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [DATA_W-1:0]   ex_reg1,
    output logic [DATA_W-1:0]   ex_reg2,
    output logic [REG_AW-1:0]   ex_wd,
    output logic                ex_wreg,
    output logic [DATA_W-1:0]   ex_inst,
    output logic [DATA_W-1:0]   ex_link_addr,
    output logic                ex_is_in_delayslot,
    output logic                ex_valid,
    output logic                is_in_delayslot_o,
    output logic [CNT_W-1:0]    bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Stage action decoded once so the data path and the counter agree.
    // ex_valid semantics: high while the EX-side bundle is a real instruction;
    // it is held with the bundle under stall_ex and there is no ready path back.
    logic do_hold;
    logic do_bubble;

    always_comb begin
        do_hold   = 1'b0;
        do_bubble = 1'b0;
        if (!flush) begin
            if (stall_ex) begin
                do_hold = 1'b1;
            end else if (stall_id) begin
                do_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_aluop           <= '0;
            ex_alusel          <= '0;
            ex_reg1            <= '0;
            ex_reg2            <= '0;
            ex_wd              <= '0;
            ex_wreg            <= 1'b0;
            ex_inst            <= '0;
            ex_link_addr       <= '0;
            ex_is_in_delayslot <= 1'b0;
            ex_valid           <= 1'b0;
            is_in_delayslot_o  <= 1'b0;
        end else if (flush || do_bubble) begin
            // Flush and bubble share the all-zero NOP; only flush drops the
            // delay-slot feedback, a bubble keeps it for the stalled ID.
            ex_aluop           <= '0;
            ex_alusel          <= '0;
            ex_reg1            <= '0;
            ex_reg2            <= '0;
            ex_wd              <= '0;
            ex_wreg            <= 1'b0;
            ex_inst            <= '0;
            ex_link_addr       <= '0;
            ex_is_in_delayslot <= 1'b0;
            ex_valid           <= 1'b0;
            if (flush) begin
                is_in_delayslot_o <= 1'b0;
            end
        end else if (!do_hold) begin
            ex_aluop           <= id_aluop;
            ex_alusel          <= id_alusel;
            ex_reg1            <= id_reg1;
            ex_reg2            <= id_reg2;
            ex_wd              <= id_wd;
            ex_wreg            <= id_wreg;
            ex_inst            <= id_inst;
            ex_link_addr       <= id_link_addr;
            ex_is_in_delayslot <= id_is_in_delayslot;
            ex_valid           <= 1'b1;
            is_in_delayslot_o  <= next_inst_in_delayslot_i;
        end
    end

    // Saturating bubble counter; clear beats increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (do_bubble && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

endmodule
